demux_rr_dispatcher: RTL and testbench

Packet-level round-robin dispatcher that drives a 1-to-4 demux stage: it accepts one valid/ready input stream and routes each whole packet to one of four output channels. Every packet lands on a single channel. Channels are visited in rotating order, and channels masked off by software are skipped. It sits between a single producer and four consumer lanes. It owns the demux select sequencing, the output register and backpressure.

---
 rtl/demux_pkg.sv | 32 +++
 rtl/demux_valid_1to4.sv | 18 +
 rtl/demux_rr_dispatcher.sv | 121 ++++++++++++
 tb/tb_demux_rr_dispatcher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types, sizes and the rotating channel search for the round-robin dispatcher.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // First enabled channel at ptr, ptr+1, ptr+2, ptr+3 (mod NUM_CH); returns ptr if none is enabled.
    function automatic logic [CH_W-1:0] next_enabled(
        input logic [CH_W-1:0]   ptr,
        input logic [NUM_CH-1:0] mask
    );
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] pick;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + CH_W'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/demux_valid_1to4.sv
// One-hot decode of the output-register valid onto the addressed channel.
module demux_valid_1to4
    import demux_pkg::*;
(
    input  logic              vld,
    input  logic [CH_W-1:0]   sel,
    output logic [NUM_CH-1:0] out_valid
);

    // Only the selected lane sees valid; all others are held low.
    always_comb begin
        out_valid = '0;
        if (vld) begin
            out_valid[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Packet-level round-robin dispatcher: one valid/ready input stream to four lanes,
// whole packets per lane, rotating over the software-enabled channels.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch
);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ptr_nxt;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   cur_ch_nxt;
    logic [CH_W-1:0]   out_ch;
    logic [CH_W-1:0]   out_ch_nxt;
    logic              vld;
    logic              vld_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              last_nxt;

    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   target;
    logic              accept;
    logic              consume;

    // Candidate for a new packet and the lane this beat is headed to.
    assign cand   = next_enabled(ptr, chan_en);
    assign target = (state == LOCKED) ? cur_ch : cand;

    // Room in the output register, and a lane to send to; never ready while in reset.
    assign in_ready = !rst
                    && (!vld || out_ready[out_ch])
                    && ((state == LOCKED) || (chan_en != '0));
    assign accept   = in_valid && in_ready;
    assign consume  = vld && out_ready[out_ch];

    assign busy      = (state == LOCKED);
    assign active_ch = cur_ch;

    // Next-state, pointer and output-register load logic.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cur_ch_nxt = cur_ch;
        vld_nxt    = vld;
        out_ch_nxt = out_ch;
        data_nxt   = out_data;
        last_nxt   = out_last;

        if (consume) begin
            vld_nxt = 1'b0;
        end

        if (accept) begin
            vld_nxt    = 1'b1;
            data_nxt   = in_data;
            last_nxt   = in_last;
            out_ch_nxt = target;
            case (state)
                IDLE: begin
                    cur_ch_nxt = cand;
                    if (in_last) begin
                        ptr_nxt = cand + CH_W'(1);
                    end else begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        ptr_nxt   = cur_ch + CH_W'(1);
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, pointer and output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cur_ch   <= '0;
            out_ch   <= '0;
            vld      <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cur_ch   <= cur_ch_nxt;
            out_ch   <= out_ch_nxt;
            vld      <= vld_nxt;
            out_data <= data_nxt;
            out_last <= last_nxt;
        end
    end

    demux_valid_1to4 u_valid_dec (
        .vld       (vld),
        .sel       (out_ch),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed self-checking bench for the round-robin packet dispatcher.
module tb_demux_rr_dispatcher;

    logic       clk;
    logic       rst;
    logic [3:0] chan_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [1:0] active_ch;

    int n_cmp;
    int n_bad;

    demux_rr_dispatcher #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .chan_en   (chan_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .active_ch (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the presented beat after an edge.
    task automatic chk_out(input string tag, input logic [3:0] v, input logic [7:0] d,
                           input logic l, input logic b, input logic [1:0] ac);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_data"},  32'(out_data),  32'(d));
        chk({tag, ".out_last"},  32'(out_last),  32'(l));
        chk({tag, ".busy"},      32'(busy),      32'(b));
        chk({tag, ".active_ch"}, 32'(active_ch), 32'(ac));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        chan_en   = 4'b0000;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 4'b0000;
        tick();
        chan_en   = 4'b1111;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'(0));
        tick();
        chk_out("reset", 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
        chk("reset.in_ready2", 32'(in_ready), 32'(0));

        // Basic rotation: five single-beat packets, ch0..ch3 then ch0.
        rst     = 1'b0;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            #1;
            chk("rot.in_ready", 32'(in_ready), 32'(1));
            tick();
            chk_out("rot", 4'(1 << (i % 4)), 8'hA0 + 8'(i), 1'b1, 1'b0, 2'(i % 4));
        end
        in_valid = 1'b0;
        tick();
        chk("rot.drain", 32'(out_valid), 32'(0));

        // Masked skip: pointer at 1, mask 1010 -> ch1, ch3, ch1.
        chan_en  = 4'b1010;
        in_valid = 1'b1;
        in_data  = 8'hB0;
        tick();
        chk_out("mask0", 4'b0010, 8'hB0, 1'b1, 1'b0, 2'd1);
        in_data = 8'hB1;
        tick();
        chk_out("mask1", 4'b1000, 8'hB1, 1'b1, 1'b0, 2'd3);
        in_data = 8'hB2;
        tick();
        chk_out("mask2", 4'b0010, 8'hB2, 1'b1, 1'b0, 2'd1);
        in_valid = 1'b0;
        tick();
        chk("mask.drain", 32'(out_valid), 32'(0));

        // Backpressure on a 3-beat packet to ch0 (pointer at 2, only ch0 enabled).
        chan_en  = 4'b0001;
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b0;
        tick();
        chk_out("bp.b0", 4'b0001, 8'h11, 1'b0, 1'b1, 2'd0);
        out_ready = 4'b1110;
        in_data   = 8'h22;
        #1;
        chk("bp.in_ready_stall", 32'(in_ready), 32'(0));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out("bp.hold", 4'b0001, 8'h11, 1'b0, 1'b1, 2'd0);
            chk("bp.hold.in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 4'b1111;
        #1;
        chk("bp.in_ready_resume", 32'(in_ready), 32'(1));
        tick();
        chk_out("bp.b1", 4'b0001, 8'h22, 1'b0, 1'b1, 2'd0);
        in_data = 8'h33;
        in_last = 1'b1;
        tick();
        chk_out("bp.b2", 4'b0001, 8'h33, 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        tick();
        chk("bp.drain", 32'(out_valid), 32'(0));

        // No eligible channel, then enable ch2 only (pointer at 1).
        chan_en  = 4'b0000;
        in_valid = 1'b1;
        in_data  = 8'h44;
        #1;
        chk("none.in_ready", 32'(in_ready), 32'(0));
        tick();
        chk("none.out_valid", 32'(out_valid), 32'(0));
        chk("none.in_ready2", 32'(in_ready), 32'(0));
        chan_en = 4'b0100;
        #1;
        chk("none.in_ready_en", 32'(in_ready), 32'(1));
        tick();
        chk_out("none.pkt", 4'b0100, 8'h44, 1'b1, 1'b0, 2'd2);
        in_valid = 1'b0;
        tick();

        // Mask change mid-packet: 4 beats to ch1, then next packet to ch0.
        chan_en  = 4'b0010;
        in_valid = 1'b1;
        in_data  = 8'h51;
        in_last  = 1'b0;
        tick();
        chk_out("mid.b0", 4'b0010, 8'h51, 1'b0, 1'b1, 2'd1);
        chan_en = 4'b0001;
        in_data = 8'h52;
        tick();
        chk_out("mid.b1", 4'b0010, 8'h52, 1'b0, 1'b1, 2'd1);
        in_data = 8'h53;
        tick();
        chk_out("mid.b2", 4'b0010, 8'h53, 1'b0, 1'b1, 2'd1);
        in_data = 8'h54;
        in_last = 1'b1;
        tick();
        chk_out("mid.b3", 4'b0010, 8'h54, 1'b1, 1'b0, 2'd1);
        in_data = 8'h55;
        tick();
        chk_out("mid.next", 4'b0001, 8'h55, 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        tick();

        // Reset during beat 2 of a packet to ch2; rotation restarts at ch0.
        chan_en  = 4'b0100;
        in_valid = 1'b1;
        in_data  = 8'h61;
        in_last  = 1'b0;
        tick();
        chk_out("rst.b0", 4'b0100, 8'h61, 1'b0, 1'b1, 2'd2);
        in_data = 8'h62;
        rst     = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'(0));
        tick();
        chk_out("rst.after", 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
        rst     = 1'b0;
        chan_en = 4'b1111;
        in_data = 8'h71;
        in_last = 1'b1;
        tick();
        chk_out("rst.next", 4'b0001, 8'h71, 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        tick();
        chk("rst.drain", 32'(out_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
